icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_tag_ram.sv | 51 +++++
 rtl/icache.sv | 161 ++++++++++++++++
 tb/tb_icache.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared config header for the icache slice
// Purpose : address/instruction width constants, reset polarity and a
//           word-alignment helper shared by icache and icache_tag_ram.
// Ports   : none (package).
package icache_pkg;

  localparam int   ADDR_W     = 32;
  localparam int   INST_W     = 32;
  localparam logic RST_ACTIVE = 1'b1;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_tag_ram.sv
// rtl/icache_tag_ram.sv - valid/tag/data storage for the direct-mapped icache
// Purpose : one line per index holding valid, tag and a 32-bit word.
// Ports   : clk, rst         - clock, synchronous reset (clears valid bits only)
//           rd_idx          - read index (combinational read)
//           rd_valid/tag/data - contents of the addressed line
//           wr_en/idx/tag/data - write port, sets the line valid
module icache_tag_ram
  import icache_pkg::*;
#(
  parameter int IDX_W = 7,
  parameter int TAG_W = ADDR_W - 2 - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [INST_W-1:0]  data_mem [ENTRIES];

  // Only the valid bits need clearing; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache
// Purpose : serves IF-stage fetches with 1-cycle hits; on a miss requests the
//           word from the memory controller and fills the line.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           is_jump                   - pipeline redirect, aborts a pending miss
//           if_req, if_pc             - fetch request/address from IF
//           if_inst, if_rdy, if_busy  - returned word, 1-cycle valid pulse, miss pending
//           inst_needed, inst_addr    - request/word address to memory controller
//           inst_data, inst_rdy       - fill word and its 1-cycle valid pulse
//           hit_cnt, miss_cnt         - only with ICACHE_PERF_EN defined
// Config  : ICACHE_PERF_EN adds 32-bit wrapping hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int ICACHE_ENTRIES = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_jump,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_rdy,
  output logic              if_busy,
  output logic              inst_needed,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_data,
  input  logic              inst_rdy
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(ICACHE_ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t state_q, state_d;

  logic [INST_W-1:0] if_inst_d;
  logic              if_rdy_d, if_busy_d, inst_needed_d;
  logic [ADDR_W-1:0] inst_addr_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [INST_W-1:0] rd_data;
  logic              wr_en;
  logic              hit;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^if_pc[1:0];

  // The line being filled is addressed by the latched miss address, so
  // if_pc is free to wander while the miss is outstanding.
  icache_tag_ram #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_tag_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (if_pc[2 +: IDX_W]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (inst_addr[2 +: IDX_W]),
    .wr_tag  (inst_addr[ADDR_W-1 -: TAG_W]),
    .wr_data (inst_data)
  );

  assign hit = rd_valid && (rd_tag == if_pc[ADDR_W-1 -: TAG_W]);

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) state_q <= S_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (if_req && !hit)      state_d = S_MISS;
      S_MISS:  if (inst_rdy || is_jump) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_inst_d     = if_inst;
    if_rdy_d      = 1'b0;
    if_busy_d     = if_busy;
    inst_needed_d = inst_needed;
    inst_addr_d   = inst_addr;
    wr_en         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req) begin
          if (hit) begin
            if_inst_d = rd_data;
            if_rdy_d  = !is_jump;
          end else begin
            inst_addr_d   = word_align(if_pc);
            inst_needed_d = 1'b1;
            if_busy_d     = 1'b1;
          end
        end
      end
      S_MISS: begin
        // A fill arriving with a redirect still lands in the array; only the
        // pulse back to IF is suppressed since that fetch is now stale.
        if (inst_rdy) begin
          wr_en         = 1'b1;
          if_inst_d     = inst_data;
          if_rdy_d      = !is_jump;
          inst_needed_d = 1'b0;
          if_busy_d     = 1'b0;
        end else if (is_jump) begin
          inst_needed_d = 1'b0;
          if_busy_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      if_inst     <= '0;
      if_rdy      <= 1'b0;
      if_busy     <= 1'b0;
      inst_needed <= 1'b0;
      inst_addr   <= '0;
    end else begin
      if_inst     <= if_inst_d;
      if_rdy      <= if_rdy_d;
      if_busy     <= if_busy_d;
      inst_needed <= inst_needed_d;
      inst_addr   <= inst_addr_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = (state_q == S_IDLE) && if_req && hit && !is_jump;
  assign miss_evt = (state_q == S_IDLE) && if_req && !hit;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss_evt) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_jump = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic [31:0] if_inst;
  logic        if_rdy;
  logic        if_busy;
  logic        inst_needed;
  logic [31:0] inst_addr;
  logic [31:0] inst_data = 32'h0;
  logic        inst_rdy = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache #(.ICACHE_ENTRIES(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .is_jump    (is_jump),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_rdy     (if_rdy),
    .if_busy    (if_busy),
    .inst_needed(inst_needed),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_rdy   (inst_rdy)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle fetch request; returns at the negedge after the sampling edge.
  task automatic start_req(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    tick();
    if_req = 1'b0;
  endtask

  // One-cycle fill pulse from the controller model.
  task automatic fill(input logic [31:0] data, input logic jump);
    inst_rdy  = 1'b1;
    inst_data = data;
    is_jump   = jump;
    tick();
    inst_rdy  = 1'b0;
    is_jump   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL reset_if_rdy: got %b want 0", if_rdy); end
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL reset_if_busy: got %b want 0", if_busy); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL reset_inst_needed: got %b want 0", inst_needed); end
    checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_miss_fill();
    start_req(32'h0000_1000);
    checks++; if (if_busy !== 1'b1) begin errors++; $display("FAIL miss_busy: got %b want 1", if_busy); end
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL miss_no_rdy: got %b want 0", if_rdy); end
    // Wiggle if_req/if_pc during the miss; the request must not move.
    if_req = 1'b1;
    if_pc  = 32'h0000_3000;
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_needed !== 1'b1) begin errors++; $display("FAIL miss_needed_c%0d: got %b want 1", i, inst_needed); end
      checks++; if (inst_addr !== 32'h0000_1000) begin errors++; $display("FAIL miss_addr_c%0d: got %h want 00001000", i, inst_addr); end
      if (i < 4) tick();
    end
    if_req = 1'b0;
    fill(32'h0010_0093, 1'b0);
    checks++; if (if_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy: got %b want 1", if_rdy); end
    checks++; if (if_inst !== 32'h0010_0093) begin errors++; $display("FAIL fill_inst: got %h want 00100093", if_inst); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL fill_needed_low: got %b want 0", inst_needed); end
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_low: got %b want 0", if_busy); end
    tick();
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy_pulse: got %b want 0", if_rdy); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL fill_no_restart: got %b want 0", inst_needed); end
  endtask

  task automatic test_hit();
    start_req(32'h0000_1000);
    checks++; if (if_rdy !== 1'b1) begin errors++; $display("FAIL hit_rdy: got %b want 1", if_rdy); end
    checks++; if (if_inst !== 32'h0010_0093) begin errors++; $display("FAIL hit_inst: got %h want 00100093", if_inst); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL hit_no_needed: got %b want 0", inst_needed); end
    tick();
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL hit_rdy_pulse: got %b want 0", if_rdy); end
  endtask

  task automatic test_conflict();
    start_req(32'h0000_1200);
    checks++; if (inst_needed !== 1'b1) begin errors++; $display("FAIL conflict_miss: got %b want 1", inst_needed); end
    checks++; if (inst_addr !== 32'h0000_1200) begin errors++; $display("FAIL conflict_addr: got %h want 00001200", inst_addr); end
    tick();
    fill(32'h0020_0113, 1'b0);
    checks++; if (if_inst !== 32'h0020_0113) begin errors++; $display("FAIL conflict_inst: got %h want 00200113", if_inst); end
    tick();
    start_req(32'h0000_1000);
    checks++; if (inst_needed !== 1'b1) begin errors++; $display("FAIL evicted_miss: got %b want 1", inst_needed); end
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL evicted_no_rdy: got %b want 0", if_rdy); end
    fill(32'h0010_0093, 1'b0);
    checks++; if (if_inst !== 32'h0010_0093) begin errors++; $display("FAIL refill_inst: got %h want 00100093", if_inst); end
    tick();
  endtask

  task automatic test_jump_abort();
    start_req(32'h0000_2000);
    tick();
    is_jump = 1'b1;
    tick();
    is_jump = 1'b0;
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL abort_needed: got %b want 0", inst_needed); end
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", if_busy); end
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL abort_rdy: got %b want 0", if_rdy); end
    tick();
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL abort_rdy_later: got %b want 0", if_rdy); end
    start_req(32'h0000_2000);
    checks++; if (inst_needed !== 1'b1) begin errors++; $display("FAIL abort_no_fill: got %b want 1", inst_needed); end
    is_jump = 1'b1;
    tick();
    is_jump = 1'b0;
    tick();
  endtask

  task automatic test_jump_with_rdy();
    start_req(32'h0000_2000);
    tick();
    fill(32'hDEAD_BEEF, 1'b1);
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL jumprdy_no_rdy: got %b want 0", if_rdy); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL jumprdy_needed: got %b want 0", inst_needed); end
    tick();
    start_req(32'h0000_2000);
    checks++; if (if_rdy !== 1'b1) begin errors++; $display("FAIL jumprdy_hit_rdy: got %b want 1", if_rdy); end
    checks++; if (if_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL jumprdy_hit_inst: got %h want deadbeef", if_inst); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL jumprdy_hit_needed: got %b want 0", inst_needed); end
    tick();
  endtask

  task automatic test_jump_idle();
    is_jump = 1'b1;
    start_req(32'h0000_2000);
    is_jump = 1'b0;
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL idlejump_rdy: got %b want 0", if_rdy); end
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL idlejump_needed: got %b want 0", inst_needed); end
    tick();
  endtask

  task automatic test_reset_mid_miss();
    start_req(32'h0000_1000);
    fill(32'h0010_0093, 1'b0);
    tick();
    start_req(32'h0000_1000);
    checks++; if (if_rdy !== 1'b1) begin errors++; $display("FAIL prerst_hit: got %b want 1", if_rdy); end
    tick();
    start_req(32'h0000_1004);
    checks++; if (inst_needed !== 1'b1) begin errors++; $display("FAIL prerst_miss: got %b want 1", inst_needed); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (inst_needed !== 1'b0) begin errors++; $display("FAIL midrst_needed: got %b want 0", inst_needed); end
    checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", inst_addr); end
    checks++; if (if_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", if_busy); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL midrst_inst: got %h want 0", if_inst); end
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b want 0", if_rdy); end
`ifdef ICACHE_PERF_EN
    checks++; if (hit_cnt !== 32'h0) begin errors++; $display("FAIL midrst_hit_cnt: got %0d want 0", hit_cnt); end
    checks++; if (miss_cnt !== 32'h0) begin errors++; $display("FAIL midrst_miss_cnt: got %0d want 0", miss_cnt); end
`endif
    tick();
    start_req(32'h0000_1000);
    checks++; if (inst_needed !== 1'b1) begin errors++; $display("FAIL postrst_miss: got %b want 1", inst_needed); end
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL postrst_no_rdy: got %b want 0", if_rdy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_conflict();
    test_jump_abort();
    test_jump_with_rdy();
    test_jump_idle();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
